// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: memory funct3 codes, FSM states and request decode helpers
package data_mem_responder_pkg;
  localparam logic [2:0] FUNCT3_MEM_BYTE   = 3'b000;
  localparam logic [2:0] FUNCT3_MEM_HALF   = 3'b001;
  localparam logic [2:0] FUNCT3_MEM_WORD   = 3'b010;
  localparam logic [2:0] FUNCT3_MEM_BYTE_U = 3'b100;
  localparam logic [2:0] FUNCT3_MEM_HALF_U = 3'b101;
  localparam int MEM_MAX_LATENCY = 4;
  typedef enum logic [1:0] {
    MEM_STATE_IDLE = 2'd0,
    MEM_STATE_WAIT = 2'd1,
    MEM_STATE_RESP = 2'd2
  } mem_state_e;
  // Unsigned loads are only legal for reads; sizes above a byte need natural alignment.
  function automatic logic mem_req_legal(input logic wr, input logic [2:0] f3, input logic [1:0] lo);
    return (f3 == FUNCT3_MEM_BYTE) || (f3 == FUNCT3_MEM_BYTE_U && !wr) ||
           ((f3 == FUNCT3_MEM_HALF || (f3 == FUNCT3_MEM_HALF_U && !wr)) && !lo[0]) ||
           (f3 == FUNCT3_MEM_WORD && lo == 2'b00);
  endfunction
  function automatic logic [3:0] mem_store_mask(input logic [2:0] f3, input logic [1:0] lo);
    return f3 == FUNCT3_MEM_BYTE ? 4'b0001 << lo :
           f3 == FUNCT3_MEM_HALF ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bus between the core initiator and the responder
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  modport master (
    output req_valid, req_write, req_funct3, req_address, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );
  modport slave (
    input  req_valid, req_write, req_funct3, req_address, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_mem_responder_load_align.sv
// mem_load_align: selects the addressed byte/half of a word and sign/zero extends it
module mem_load_align
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  always_comb begin
    o_data = i_funct3 == FUNCT3_MEM_BYTE   ? {{24{w_byte[7]}}, w_byte} :
             i_funct3 == FUNCT3_MEM_BYTE_U ? {24'b0, w_byte} :
             i_funct3 == FUNCT3_MEM_HALF   ? {{16{w_half[15]}}, w_half} :
             i_funct3 == FUNCT3_MEM_HALF_U ? {16'b0, w_half} : i_word;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency byte/half/word load-store responder over local word SRAM
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input logic i_clk,
  input logic i_rst,
  data_mem_responder_if.slave io_bus
);
  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  if (LATENCY < 1 || LATENCY > MEM_MAX_LATENCY) begin : g_bad_latency
    $error("LATENCY out of range");
  end
  logic [31:0]           r_mem [DEPTH];
  mem_state_e            r_state, w_next;
  logic [2:0]            r_cnt;
  logic [ADDR_WIDTH-3:0] r_idx;
  logic [1:0]            r_lo;
  logic [2:0]            r_f3;
  logic                  r_write, r_legal;
  logic [31:0]           r_rdata;
  logic                  r_error;
  logic                  w_idle, w_accept, w_legal, w_enter, w_we;
  logic                  w_sel_write, w_sel_legal, w_unused;
  logic [ADDR_WIDTH-3:0] w_idx, w_sel_idx;
  logic [1:0]            w_sel_lo;
  logic [2:0]            w_sel_f3;
  logic [3:0]            w_mask;
  logic [31:0]           w_wlane, w_load;
  assign w_idle   = r_state == MEM_STATE_IDLE;
  assign w_accept = io_bus.req_valid && w_idle;
  assign w_idx    = io_bus.req_address[ADDR_WIDTH-1:2];
  assign w_legal  = mem_req_legal(io_bus.req_write, io_bus.req_funct3, io_bus.req_address[1:0]);
  assign w_mask   = mem_store_mask(io_bus.req_funct3, io_bus.req_address[1:0]);
  assign w_we     = w_accept && io_bus.req_write && w_legal;
  assign w_wlane  = io_bus.req_funct3 == FUNCT3_MEM_BYTE ? {4{io_bus.req_wdata[7:0]}} :
                    io_bus.req_funct3 == FUNCT3_MEM_HALF ? {2{io_bus.req_wdata[15:0]}} :
                    io_bus.req_wdata;
  assign w_unused = ^io_bus.req_address[31:ADDR_WIDTH];
  // With LATENCY==1 the response is loaded on the accept edge itself, straight from the bus.
  assign w_enter     = w_idle ? (w_accept && LATENCY == 1) : (r_state == MEM_STATE_WAIT && r_cnt == 3'd1);
  assign w_sel_idx   = w_idle ? w_idx : r_idx;
  assign w_sel_lo    = w_idle ? io_bus.req_address[1:0] : r_lo;
  assign w_sel_f3    = w_idle ? io_bus.req_funct3 : r_f3;
  assign w_sel_write = w_idle ? io_bus.req_write : r_write;
  assign w_sel_legal = w_idle ? w_legal : r_legal;
  mem_load_align u_align (
    .i_word   (r_mem[w_sel_idx]),
    .i_addr_lo(w_sel_lo),
    .i_funct3 (w_sel_f3),
    .o_data   (w_load)
  );
  always_comb begin
    w_next = r_state;
    w_next = w_enter ? MEM_STATE_RESP :
             w_accept ? MEM_STATE_WAIT :
             (r_state == MEM_STATE_RESP && io_bus.rsp_ready) ? MEM_STATE_IDLE : r_state;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= MEM_STATE_IDLE;
    else       r_state <= w_next;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_lo    <= '0;
      r_f3    <= '0;
      r_write <= 1'b0;
      r_legal <= 1'b0;
      r_rdata <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 3'(LATENCY - 1);
        r_idx   <= w_idx;
        r_lo    <= io_bus.req_address[1:0];
        r_f3    <= io_bus.req_funct3;
        r_write <= io_bus.req_write;
        r_legal <= w_legal;
      end else if (r_state == MEM_STATE_WAIT) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_enter) begin
        r_rdata <= (w_sel_write || !w_sel_legal) ? 32'd0 : w_load;
        r_error <= !w_sel_legal;
      end
    end
  end
  // Stores commit at accept; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (w_we)
      for (int b = 0; b < 4; b++)
        if (w_mask[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
  end
  assign io_bus.req_ready = w_idle;
  assign io_bus.rsp_valid = r_state == MEM_STATE_RESP;
  assign io_bus.rsp_rdata = r_rdata;
  assign io_bus.rsp_error = r_error;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench driving LATENCY=1 and LATENCY=3 responders
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;
  typedef struct packed {logic [31:0] rdata; logic error;} exp_t;
  logic clk = 0, rst = 1;
  int checks = 0, errors = 0;
  int sel = 0;
  logic v = 0, wr = 0, rdy = 1;
  logic [2:0] f3 = 0;
  logic [31:0] addr = 0, wd = 0;
  logic o_rq, o_rv, o_re;
  logic [31:0] o_rd;
  exp_t q1[$], q3[$];
  data_mem_responder_if b1 ();
  data_mem_responder_if b3 ();
  always #5 clk = ~clk;
  assign b1.req_valid = v && sel == 0;
  assign b3.req_valid = v && sel == 1;
  assign b1.req_write = wr;
  assign b3.req_write = wr;
  assign b1.req_funct3 = f3;
  assign b3.req_funct3 = f3;
  assign b1.req_address = addr;
  assign b3.req_address = addr;
  assign b1.req_wdata = wd;
  assign b3.req_wdata = wd;
  assign b1.rsp_ready = rdy;
  assign b3.rsp_ready = rdy;
  assign o_rq = sel == 1 ? b3.req_ready : b1.req_ready;
  assign o_rv = sel == 1 ? b3.rsp_valid : b1.rsp_valid;
  assign o_rd = sel == 1 ? b3.rsp_rdata : b1.rsp_rdata;
  assign o_re = sel == 1 ? b3.rsp_error : b1.rsp_error;
  data_mem_responder #(.ADDR_WIDTH(12), .LATENCY(1)) dut1 (.i_clk(clk), .i_rst(rst), .io_bus(b1));
  data_mem_responder #(.ADDR_WIDTH(12), .LATENCY(3)) dut3 (.i_clk(clk), .i_rst(rst), .io_bus(b3));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (b1.rsp_valid && b1.rsp_ready) begin
      if (q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("rsp1_rdata", b1.rsp_rdata, e.rdata);
        chk("rsp1_error", {31'b0, b1.rsp_error}, {31'b0, e.error});
      end
    end
    if (b3.rsp_valid && b3.rsp_ready) begin
      if (q3.size() == 0) chk("rsp3_unexpected", 32'd1, 32'd0);
      else begin
        e = q3.pop_front();
        chk("rsp3_rdata", b3.rsp_rdata, e.rdata);
        chk("rsp3_error", {31'b0, b3.rsp_error}, {31'b0, e.error});
      end
    end
  end
  task automatic req(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] er, input logic ee, input int hold = 0);
    int n = 0;
    int lat = sel == 1 ? 3 : 1;
    exp_t e;
    e.rdata = er;
    e.error = ee;
    wr = w; f3 = f; addr = a; wd = d; v = 1; rdy = hold == 0;
    if (sel == 1) q3.push_back(e); else q1.push_back(e);
    @(posedge clk); #1;
    v = 0;
    while (!o_rv && n < 20) begin
      chk("req_ready_wait", {31'b0, o_rq}, 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_latency", 32'(n), 32'(lat - 1));
    repeat (hold) begin
      chk("hold_valid", {31'b0, o_rv}, 32'd1);
      chk("hold_rdata", o_rd, er);
      chk("hold_req_ready", {31'b0, o_rq}, 32'd0);
      @(posedge clk); #1;
    end
    rdy = 1;
    @(posedge clk); #1;
    chk("req_ready_after", {31'b0, o_rq}, 32'd1);
    chk("rsp_valid_after", {31'b0, o_rv}, 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready1", {31'b0, b1.req_ready}, 32'd1);
    chk("reset_valid1", {31'b0, b1.rsp_valid}, 32'd0);
    chk("reset_rdata1", b1.rsp_rdata, 32'd0);
    chk("reset_ready3", {31'b0, b3.req_ready}, 32'd1);
    rst = 0;
    @(posedge clk); #1;
    sel = 0;
    req(1, FUNCT3_MEM_WORD,   32'h10, 32'hDEADBEEF, 32'h0,        0);
    req(0, FUNCT3_MEM_WORD,   32'h10, 32'h0,        32'hDEADBEEF, 0);
    req(1, FUNCT3_MEM_BYTE,   32'h13, 32'h80,       32'h0,        0);
    req(0, FUNCT3_MEM_BYTE,   32'h13, 32'h0,        32'hFFFFFF80, 0);
    req(0, FUNCT3_MEM_BYTE_U, 32'h13, 32'h0,        32'h00000080, 0);
    req(0, FUNCT3_MEM_WORD,   32'h10, 32'h0,        32'h80ADBEEF, 0);
    req(0, FUNCT3_MEM_HALF,   32'h12, 32'h0,        32'hFFFF80AD, 0);
    req(0, FUNCT3_MEM_HALF_U, 32'h10, 32'h0,        32'h0000BEEF, 0);
    req(0, FUNCT3_MEM_BYTE,   32'h11, 32'h0,        32'hFFFFFFBE, 0);
    req(0, FUNCT3_MEM_HALF,   32'h11, 32'h0,        32'h0,        1);
    req(1, FUNCT3_MEM_WORD,   32'h12, 32'h11111111, 32'h0,        1);
    req(0, FUNCT3_MEM_WORD,   32'h10, 32'h0,        32'h80ADBEEF, 0);
    req(1, 3'b100,            32'h10, 32'h0,        32'h0,        1);
    req(0, FUNCT3_MEM_WORD,   32'h10, 32'h0,        32'h80ADBEEF, 0);
    req(0, 3'b011,            32'h10, 32'h0,        32'h0,        1);
    req(1, FUNCT3_MEM_WORD,   32'h14, 32'hA5A5A5A5, 32'h0,        0);
    req(1, FUNCT3_MEM_HALF,   32'h16, 32'h00001234, 32'h0,        0);
    req(0, FUNCT3_MEM_WORD,   32'h14, 32'h0,        32'h1234A5A5, 0);
    sel = 1;
    req(1, FUNCT3_MEM_WORD,   32'h30, 32'hCAFEF00D, 32'h0,        0);
    req(0, FUNCT3_MEM_HALF_U, 32'h32, 32'h0,        32'h0000CAFE, 0, 5);
    wr = 1; f3 = FUNCT3_MEM_WORD; addr = 32'h20; wd = 32'h12345678; v = 1;
    @(posedge clk); #1;
    v = 0;
    chk("wait_req_ready", {31'b0, o_rq}, 32'd0);
    #2 rst = 1;
    #1;
    chk("async_ready", {31'b0, o_rq}, 32'd1);
    chk("async_valid", {31'b0, o_rv}, 32'd0);
    chk("async_rdata", o_rd, 32'd0);
    chk("async_error", {31'b0, o_re}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    req(0, FUNCT3_MEM_WORD,   32'h20, 32'h0,        32'h12345678, 0);
    sel = 0;
    req(0, FUNCT3_MEM_WORD,   32'h1010, 32'h0,      32'h80ADBEEF, 0);
    req(1, FUNCT3_MEM_BYTE,   32'h1014, 32'h55,     32'h0,        0);
    req(0, FUNCT3_MEM_WORD,   32'h14, 32'h0,        32'h1234A555, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
